// File: rtl/stack_prog_sequencer.sv
// Program replay front end for the signed stack machine: issues stored stack instructions and checks the stack's flags after each one.
// Define STACK_SEQ_OVF_HALT_EN to halt with err_code 3 on arithmetic overflow instead of only flagging it in ovf_seen.
module stack_prog_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int PROG_DEPTH  = 32,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_en,
    input  logic [ADDR_WIDTH-1:0]        load_addr,
    input  logic [DATA_WIDTH+2:0]        load_instr,
    input  logic                         start,
    input  logic [ADDR_WIDTH:0]          prog_len,
    output logic [2:0]                   opcode,
    output logic signed [DATA_WIDTH-1:0] data_in,
    input  logic signed [DATA_WIDTH-1:0] stack_data_out,
    input  logic                         stack_overflow,
    output logic                         busy,
    output logic                         done,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         result_valid,
    output logic                         error,
    output logic [2:0]                   err_code,
    output logic                         ovf_seen
);

    localparam int INSTR_W = DATA_WIDTH + 3;
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
    localparam logic [2:0] ERR_FULL      = 3'd2;
    localparam logic [2:0] ERR_ILLEGAL   = 3'd4;
`ifdef STACK_SEQ_OVF_HALT_EN
    localparam logic [2:0] ERR_ARITH     = 3'd3;
`endif

    logic [INSTR_W-1:0]  mem [PROG_DEPTH];
    logic [2:0]          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH:0] pc_inc;
    logic [DEPTH_W-1:0]  depth;
    logic [INSTR_W-1:0]  ir;
    logic [INSTR_W-1:0]  fetch_instr;
    logic [2:0]          fetch_op;
    logic [2:0]          fetch_err;
    logic [2:0]          ir_op;
    logic                result_op;
    logic                arith_op;
    logic                res_flag;

    assign fetch_instr = mem[pc];
    assign fetch_op    = fetch_instr[INSTR_W-1 -: 3];
    assign ir_op       = ir[INSTR_W-1 -: 3];
    assign arith_op    = (ir_op == OP_ADD) || (ir_op == OP_MUL);
    assign result_op   = arith_op || (ir_op == OP_POP);
    assign pc_inc      = {1'b0, pc} + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // The depth counter mirrors the stack so misuse is caught before any opcode reaches it.
    always_comb begin
        fetch_err = ERR_NONE;
        case (fetch_op)
            OP_NOP:         fetch_err = ERR_NONE;
            OP_POP:         if (depth == '0) fetch_err = ERR_UNDERFLOW;
            OP_ADD, OP_MUL: if (depth < DEPTH_W'(2)) fetch_err = ERR_UNDERFLOW;
            OP_PUSH:        if (depth == DEPTH_W'(STACK_DEPTH)) fetch_err = ERR_FULL;
            default:        fetch_err = ERR_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_en && (state == S_IDLE))
            mem[load_addr] <= load_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            depth    <= '0;
            ir       <= '0;
            res_flag <= 1'b0;
            result   <= '0;
            ovf_seen <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        res_flag <= 1'b0;
                        if (prog_len == '0) begin
                            state <= S_DONE;
                        end else begin
                            pc       <= '0;
                            ovf_seen <= 1'b0;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    ir <= fetch_instr;
                    if (fetch_err != ERR_NONE) begin
                        err_code <= fetch_err;
                        state    <= S_ERROR;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ir_op == OP_PUSH)
                        depth <= depth + DEPTH_W'(1);
                    else if (result_op)
                        depth <= depth - DEPTH_W'(1);
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    // Stack outputs settle one cycle after it samples the opcode.
                    if (result_op) begin
                        result   <= stack_data_out;
                        res_flag <= 1'b1;
                    end
                    if (arith_op && stack_overflow)
                        ovf_seen <= 1'b1;
`ifdef STACK_SEQ_OVF_HALT_EN
                    if (arith_op && stack_overflow) begin
                        err_code <= ERR_ARITH;
                        state    <= S_ERROR;
                    end else begin
                        pc    <= pc_inc[ADDR_WIDTH-1:0];
                        state <= (pc_inc == prog_len) ? S_DONE : S_FETCH;
                    end
`else
                    pc    <= pc_inc[ADDR_WIDTH-1:0];
                    state <= (pc_inc == prog_len) ? S_DONE : S_FETCH;
`endif
                end
                S_DONE:  state <= S_IDLE;
                // Only rst leaves ERROR, since the stack itself needs resetting too.
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state == S_FETCH) || (state == S_ISSUE) || (state == S_CHECK);
    assign done         = (state == S_DONE);
    assign error        = (state == S_ERROR);
    assign result_valid = done && res_flag;
    assign opcode       = (state == S_ISSUE) ? ir_op : OP_NOP;
    assign data_in      = (state == S_ISSUE) ? $signed(ir[DATA_WIDTH-1:0]) : '0;

endmodule

// File: tb/tb_stack_prog_sequencer.sv
// Scoreboard bench for stack_prog_sequencer with a behavioural signed stack attached to its opcode port.
// Expectations for the overflow program follow STACK_SEQ_OVF_HALT_EN when it is defined.
module tb_stack_prog_sequencer;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    logic              clk;
    logic              rst;
    logic              load_en;
    logic [4:0]        load_addr;
    logic [10:0]       load_instr;
    logic              start;
    logic [5:0]        prog_len;
    logic [2:0]        opcode;
    logic signed [7:0] data_in;
    logic signed [7:0] stack_data_out;
    logic              stack_overflow;
    logic              busy;
    logic              done;
    logic signed [7:0] result;
    logic              result_valid;
    logic              error;
    logic [2:0]        err_code;
    logic              ovf_seen;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              err;
        logic [2:0]        code;
        logic signed [7:0] res;
        logic              rv;
        logic              ovf;
        int                cyc;
        int                issued;
    } exp_t;

    exp_t exp_q[$];

    stack_prog_sequencer dut (
        .clk(clk),
        .rst(rst),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_instr(load_instr),
        .start(start),
        .prog_len(prog_len),
        .opcode(opcode),
        .data_in(data_in),
        .stack_data_out(stack_data_out),
        .stack_overflow(stack_overflow),
        .busy(busy),
        .done(done),
        .result(result),
        .result_valid(result_valid),
        .error(error),
        .err_code(err_code),
        .ovf_seen(ovf_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: samples the opcode at the clock edge and presents its result one cycle later.
    logic signed [7:0] stk [16];
    logic [4:0]        sp;
    int                op_a, op_b, sum_full, prod_full;

    always_comb begin
        op_a      = (sp >= 5'd2) ? int'(stk[4'(sp - 5'd2)]) : 0;
        op_b      = (sp >= 5'd1) ? int'(stk[4'(sp - 5'd1)]) : 0;
        sum_full  = op_a + op_b;
        prod_full = op_a * op_b;
    end

    always @(posedge clk) begin
        if (rst) begin
            sp             <= 5'd0;
            stack_data_out <= '0;
            stack_overflow <= 1'b0;
        end else begin
            case (opcode)
                OP_PUSH: if (sp < 5'd16) begin
                    stk[4'(sp)] <= data_in;
                    sp          <= sp + 5'd1;
                end
                OP_POP: if (sp >= 5'd1) begin
                    stack_data_out <= stk[4'(sp - 5'd1)];
                    stack_overflow <= 1'b0;
                    sp             <= sp - 5'd1;
                end
                OP_ADD: if (sp >= 5'd2) begin
                    stk[4'(sp - 5'd2)] <= 8'(sum_full);
                    stack_data_out     <= 8'(sum_full);
                    stack_overflow     <= (sum_full > 127) || (sum_full < -128);
                    sp                 <= sp - 5'd1;
                end
                OP_MUL: if (sp >= 5'd2) begin
                    stk[4'(sp - 5'd2)] <= 8'(prod_full);
                    stack_data_out     <= 8'(prod_full);
                    stack_overflow     <= (prod_full > 127) || (prod_full < -128);
                    sp                 <= sp - 5'd1;
                end
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic err, input logic [2:0] code, input int res,
                           input logic rv, input logic ovf, input int cyc, input int issued);
        exp_t e;
        e.err    = err;
        e.code   = code;
        e.res    = 8'(res);
        e.rv     = rv;
        e.ovf    = ovf;
        e.cyc    = cyc;
        e.issued = issued;
        exp_q.push_back(e);
    endtask

    task automatic checkReset();
        checkOutput("rst_opcode", opcode, 3'b000);
        checkOutput("rst_data_in", data_in, 8'sd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_result", result, 8'sd0);
        checkOutput("rst_result_valid", result_valid, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_err_code", err_code, 3'd0);
        checkOutput("rst_ovf_seen", ovf_seen, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset();
        @(posedge clk); #1;
    endtask

    function automatic logic [10:0] mk(input logic [2:0] op, input int imm);
        return {op, 8'(imm)};
    endfunction

    task automatic loadInstr(input int addr, input logic [2:0] op, input int imm);
        load_en    = 1'b1;
        load_addr  = 5'(addr);
        load_instr = mk(op, imm);
        @(posedge clk); #1;
        load_en    = 1'b0;
    endtask

    // Starts a run, optionally hammering start/load_en while busy, and waits for the monitor to drain the queue.
    task automatic applyStimulus(input int len, input bit disturb);
        int budget;
        prog_len = 6'(len);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) begin
            repeat (3) begin
                start      = 1'b1;
                load_en    = 1'b1;
                load_addr  = 5'd0;
                load_instr = mk(3'b010, 0);
                @(posedge clk); #1;
            end
            start   = 1'b0;
            load_en = 1'b0;
        end
        budget = 3 * len + 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL completion_timeout: got no done/error, expected one within %0d cycles", 3 * len + 20);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: counts cycles and issued opcodes from the start edge, pops the scoreboard on done or error entry.
    initial begin
        int   run_cycles;
        int   run_issued;
        logic err_prev;
        exp_t e;
        run_cycles = 0;
        run_issued = 0;
        err_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (start && !busy && !done && !error) begin
                    run_cycles = 0;
                    run_issued = 0;
                end else begin
                    run_cycles++;
                    if (opcode != 3'b000) run_issued++;
                    if (done || (error && !err_prev)) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_completion: got done=%0d error=%0d, expected none", done, error);
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("end_is_error", error, e.err);
                            checkOutput("err_code", err_code, e.code);
                            checkOutput("result", result, e.res);
                            checkOutput("result_valid", result_valid, e.rv);
                            checkOutput("ovf_seen", ovf_seen, e.ovf);
                            checkOutput("cycles", run_cycles, e.cyc);
                            checkOutput("issued", run_issued, e.issued);
                        end
                    end
                end
            end
            err_prev = error;
        end
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_instr = '0;
        prog_len   = '0;
        @(posedge clk); #1;
        doReset();

        $display("[TB] empty program");
        pushExp(1'b0, 3'd0, 0, 1'b0, 1'b0, 1, 0);
        applyStimulus(0, 1'b0);

        $display("[TB] push 3, push 5, add");
        loadInstr(0, OP_PUSH, 3);
        loadInstr(1, OP_PUSH, 5);
        loadInstr(2, OP_ADD, 0);
        pushExp(1'b0, 3'd0, 8, 1'b1, 1'b0, 10, 3);
        applyStimulus(3, 1'b0);

        $display("[TB] push 127, push 2, add");
        loadInstr(0, OP_PUSH, 127);
        loadInstr(1, OP_PUSH, 2);
        loadInstr(2, OP_ADD, 0);
`ifdef STACK_SEQ_OVF_HALT_EN
        pushExp(1'b1, 3'd3, -127, 1'b0, 1'b1, 10, 3);
`else
        pushExp(1'b0, 3'd0, -127, 1'b1, 1'b1, 10, 3);
`endif
        applyStimulus(3, 1'b0);
        doReset();

        $display("[TB] push -20, push -5, nop, mul, pop");
        loadInstr(0, OP_PUSH, -20);
        loadInstr(1, OP_PUSH, -5);
        loadInstr(2, OP_NOP, 0);
        loadInstr(3, OP_MUL, 0);
        loadInstr(4, OP_POP, 0);
        pushExp(1'b0, 3'd0, 100, 1'b1, 1'b0, 16, 4);
        applyStimulus(5, 1'b0);

        $display("[TB] push 7, push -8, mul");
        loadInstr(0, OP_PUSH, 7);
        loadInstr(1, OP_PUSH, -8);
        loadInstr(2, OP_MUL, 0);
        pushExp(1'b0, 3'd0, -56, 1'b1, 1'b0, 10, 3);
        applyStimulus(3, 1'b0);

        $display("[TB] start/load_en while busy");
        pushExp(1'b0, 3'd0, -56, 1'b0, 1'b0, 4, 1);
        applyStimulus(1, 1'b1);
        pushExp(1'b0, 3'd0, -56, 1'b0, 1'b0, 4, 1);
        applyStimulus(1, 1'b0);

        $display("[TB] add on empty stack");
        doReset();
        loadInstr(0, OP_ADD, 0);
        pushExp(1'b1, 3'd1, 0, 1'b0, 1'b0, 2, 0);
        applyStimulus(1, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("error_sticky_busy", busy, 1'b0);
        checkOutput("error_sticky", error, 1'b1);
        checkOutput("error_sticky_code", err_code, 3'd1);
        @(posedge clk); #1;

        $display("[TB] 17 pushes");
        doReset();
        for (int i = 0; i < 17; i++) loadInstr(i, OP_PUSH, i + 1);
        pushExp(1'b1, 3'd2, 0, 1'b0, 1'b0, 50, 16);
        applyStimulus(17, 1'b0);

        $display("[TB] illegal opcode");
        doReset();
        loadInstr(0, 3'b010, 0);
        pushExp(1'b1, 3'd4, 0, 1'b0, 1'b0, 2, 0);
        applyStimulus(1, 1'b0);

        $display("[TB] reset during CHECK");
        doReset();
        loadInstr(0, OP_PUSH, 5);
        loadInstr(1, OP_POP, 0);
        pushExp(1'b0, 3'd0, 5, 1'b1, 1'b0, 7, 2);
        applyStimulus(2, 1'b0);
        prog_len = 6'd2;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkReset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected it before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/stack_prog_sequencer.md
# stack_prog_sequencer

Instruction-issuing front end for the signed stack machine: holds a small program of stack instructions, replays it into the stack's `opcode`/`data_in` port one instruction at a time, and checks the stack's response flags after each one. It replaces bench-style hand-driven opcode streams with a self-checking initiator. It sits beside the stack on the same `clk`/`rst`, reports the final result, and halts on stack misuse.

## Interface
- `DATA_WIDTH`, 8: operand width; must match the stack.
- `STACK_DEPTH`, 16: stack capacity; must match the stack.
- `PROG_DEPTH`, 32: program memory entries.
- `ADDR_WIDTH`, 5: program address width, clog2(PROG_DEPTH).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `load_en` in 1: write `load_instr` to `load_addr`. Ignored unless IDLE.
- `load_addr` in ADDR_WIDTH: program write address.
- `load_instr` in DATA_WIDTH+3: {opcode[2:0], signed immediate}.
- `start` in 1: run `prog_len` instructions from address 0. Sampled in IDLE only.
- `prog_len` in ADDR_WIDTH+1: instruction count, 0..PROG_DEPTH.
- `opcode` out 3: to stack. 000 nop, 100 add, 101 mul, 110 push, 111 pop.
- `data_in` out DATA_WIDTH signed: to stack, push operand.
- `stack_data_out` in DATA_WIDTH signed: from stack.
- `stack_overflow` in 1: from stack.
- `busy` out 1: high in FETCH/ISSUE/CHECK.
- `done` out 1: one-cycle pulse at program completion.
- `result` out DATA_WIDTH signed: last value captured from a pop/add/mul.
- `result_valid` out 1: high with `done` if at least one pop/add/mul ran.
- `error` out 1: sticky, high in ERROR.
- `err_code` out 3: 0 none, 1 underflow, 2 full, 3 arithmetic overflow, 4 illegal opcode.
- `ovf_seen` out 1: sticky, set by any arithmetic overflow during a run.

## Operation
- States: IDLE, FETCH, ISSUE, CHECK, DONE, ERROR.
- IDLE: `start` with `prog_len`=0 goes to DONE. `start` with a non-zero length clears `pc`, `ovf_seen`, and `result_valid`, then goes to FETCH.
- FETCH: synchronous read of `mem[pc]`. The pre-check uses an internal `depth` counter (0..STACK_DEPTH):
  - pop with depth 0, or add/mul with depth<2, goes to ERROR with code 1.
  - push with depth==STACK_DEPTH goes to ERROR with code 2.
  - opcode 001/010/011 goes to ERROR with code 4.
  - Otherwise go to ISSUE.
- ISSUE: drive the instruction's opcode and immediate for exactly one cycle. Update depth: push +1, pop −1, add/mul −1, nop 0. Go to CHECK.
- CHECK: `opcode`=000. For pop/add/mul, capture `stack_data_out` into `result` and set the internal result flag. For add/mul with `stack_overflow`=1, set `ovf_seen`; overflow handling is set by Configuration. Then `pc`+1; if `pc`+1==`prog_len` go to DONE, else FETCH.
- DONE: `done`=1 for one cycle, `result_valid` reflects the result flag. Return to IDLE. `result` holds its value until the next `start`.
- ERROR: `opcode`=000, `error`=1. The state is left only by `rst`, because the stack must also be reset.
- `depth` persists across runs, since the stack keeps its contents. It is cleared only by `rst`.
- `start` or `load_en` while not IDLE is ignored.

## Timing
- Reset values: `opcode`=000, `data_in`=0, `busy`=0, `done`=0, `result`=0, `result_valid`=0, `error`=0, `err_code`=0, `ovf_seen`=0, `depth`=0, `pc`=0, state IDLE. Program memory is not cleared.
- `rst` mid-run aborts on the next edge with no further opcodes issued.
- Each instruction takes 3 cycles (FETCH, ISSUE, CHECK).
- The stack samples `opcode` at the end of ISSUE. Its outputs are sampled at the end of CHECK, one cycle of stack latency.
- An N-instruction program takes 3N+1 cycles from the `start` edge to the `done` pulse. `prog_len`=0 takes 1 cycle.
- The error path issues no opcode: ERROR is entered at the end of FETCH.
- `load_en` writes on the clock edge; a read in the same cycle returns old data.

## Configuration
- `STACK_SEQ_OVF_HALT_EN` defined: an add/mul with `stack_overflow`=1 goes from CHECK to ERROR with code 3 (`ovf_seen` also set). `result` holds the wrapped value.
- Not defined: overflow only sets `ovf_seen`; execution continues.

## Test plan
- Program push 3, push 5, add (len 3) -> 10 cycles to `done`, `result`=8, `result_valid`=1, `ovf_seen`=0, `error`=0.
- push 127, push 2, add -> `result`=−127, `ovf_seen`=1. With `STACK_SEQ_OVF_HALT_EN`: `error`=1, `err_code`=3, `done` never pulses.
- push −20, push −5, mul, pop -> `result`=100. Push 7, push −8, mul -> `result`=−56, no overflow.
- After `rst`, run a single add -> ERROR with code 1, `opcode` never leaves 000. Next run: 17 pushes -> ERROR with code 2 at instruction 17.
- Opcode 010 at address 0 -> `err_code`=4. `start`/`load_en` during busy are ignored. `rst` during CHECK -> all outputs at reset values next cycle.
- `prog_len`=0 -> `done` 1 cycle after `start`, `result_valid`=0.
